keystroke_decoder: RTL
======================

KEYSTROKE_DECODER -- requirements
Module: keystroke_decoder

Interface
REQ-001 Parameter: REPEAT_SUPPRESS, default 1, 1 = typematic repeats of the held letter produce no pulse.
REQ-002 CLOCK_50  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 scan_code  in  8  PS/2 set-2 byte from the keyboard receiver, sampled only when scan_valid=1.
REQ-005 scan_valid  in  1  one-cycle strobe per received byte, CLOCK_50 domain.
REQ-006 letter_valid  out  1  one-cycle pulse per accepted letter press; this is the rotor-step / encipher strobe.
REQ-007 letter_idx  out  5  letter of the last pulse, 0=A .. 25=Z.
REQ-008 letter_onehot  out  26  one-hot of letter_idx while key_held=1, else all zero; bit 0 = A. Feeds the plugboard.
REQ-009 key_held  out  1  a letter key is currently held.

Function
REQ-010 FSM states: IDLE, BRK (0xF0 seen), EXT (0xE0 seen), EXT_BRK (0xE0 0xF0 seen); the FSM advances only on cycles with scan_valid=1.
REQ-011 IDLE: 0xF0 -> BRK; 0xE0 -> EXT; any other byte stays in IDLE and is handled as a make code.
REQ-012 Letter map (make code -> idx): 1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M, 31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z.
REQ-013 Letter make code in IDLE:
- If key_held=0, or the code differs from held_code: pulse letter_valid, load letter_idx, set key_held=1, and set held_code to the code.
- If the code equals held_code and REPEAT_SUPPRESS=1: no pulse and no state change.
- If REPEAT_SUPPRESS=0, the repeated code pulses again.
REQ-014 Non-letter make code in IDLE: no pulse; key_held, held_code and letter_idx unchanged.
REQ-015 BRK: the next byte returns the FSM to IDLE with no pulse; if that byte equals held_code and key_held=1, clear key_held; otherwise held state is unchanged.
REQ-016 EXT: 0xF0 -> EXT_BRK; any other byte -> IDLE. No pulse and no held-state change.
REQ-017 EXT_BRK: any byte -> IDLE. No pulse and no held-state change.
REQ-018 Latency: letter_valid is asserted exactly one cycle after the scan_valid cycle that carried the make code, and is never high for two consecutive cycles.
REQ-019 letter_idx and letter_onehot update in the same cycle letter_valid rises; letter_idx holds its value until the next pulse, including across release.
REQ-020 Rollover: a second letter make while another letter is held pulses and replaces held_code; a later break of the first letter is ignored.
REQ-021 scan_valid=0 cycles change no state; there is no timeout.

Reset
REQ-022 While reset=1 the FSM is in IDLE, letter_valid=0, letter_idx=0, letter_onehot=0, key_held=0 and held_code=0x00.
REQ-023 reset has priority over a coincident scan_valid, and that byte is discarded.
REQ-024 Reset asserted mid-sequence (BRK, EXT, EXT_BRK) abandons the sequence; the first byte after reset is decoded from IDLE.

Structure
REQ-025 Shared package enigma_pkg holds:
- the 26 letter scan-code constants;
- BREAK_PREFIX = 8'hF0 and EXT_PREFIX = 8'hE0;
- LETTER_COUNT = 26;
- a 5-bit letter index type;
- the FSM state encoding.
REQ-026 One combinational sub-module, scan_to_letter: scan_code in; is_letter and 5-bit idx out. All sequential logic stays in keystroke_decoder.

Verification
REQ-027 Reset, then byte 0x1C -> next cycle letter_valid=1, letter_idx=0, letter_onehot=26'h0000001, key_held=1.
REQ-028 Bytes 0x1C, 0x1C, 0x1C with REPEAT_SUPPRESS=1 -> exactly one pulse; with REPEAT_SUPPRESS=0 -> three pulses, idx=0 each.
REQ-029 Bytes 0x1C, 0xF0, 0x1C -> one pulse, then key_held=0 and letter_onehot=0 while letter_idx stays 0; a further 0x1C -> second pulse, idx=0.
REQ-030 Bytes 0xE0, 0x1C then 0xE0, 0xF0, 0x1C -> no pulses; a following 0x32 -> pulse with idx=1.
REQ-031 Bytes 0x1C, 0x1A, 0xF0, 0x1C -> pulses with idx 0 then 25; after the break, key_held=1, letter_idx=25, letter_onehot=26'h2000000.
REQ-032 Byte 0xF0, then reset for 1 cycle, then 0x1C -> treated as make, pulse with idx=0; reset coincident with scan_valid of 0x24 -> no pulse.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared definitions for the keyboard front end of the Enigma design.
// Holds the PS/2 set-2 make codes for the 26 letter keys, the break and
// extended prefix bytes, the letter index type and the decoder FSM encoding.
package enigma_pkg;

    localparam int LETTER_COUNT = 26;

    localparam logic [7:0] BREAK_PREFIX = 8'hF0;
    localparam logic [7:0] EXT_PREFIX   = 8'hE0;

    // PS/2 set-2 make codes, one per letter key.
    localparam logic [7:0] SC_A = 8'h1C;
    localparam logic [7:0] SC_B = 8'h32;
    localparam logic [7:0] SC_C = 8'h21;
    localparam logic [7:0] SC_D = 8'h23;
    localparam logic [7:0] SC_E = 8'h24;
    localparam logic [7:0] SC_F = 8'h2B;
    localparam logic [7:0] SC_G = 8'h34;
    localparam logic [7:0] SC_H = 8'h33;
    localparam logic [7:0] SC_I = 8'h43;
    localparam logic [7:0] SC_J = 8'h3B;
    localparam logic [7:0] SC_K = 8'h42;
    localparam logic [7:0] SC_L = 8'h4B;
    localparam logic [7:0] SC_M = 8'h3A;
    localparam logic [7:0] SC_N = 8'h31;
    localparam logic [7:0] SC_O = 8'h44;
    localparam logic [7:0] SC_P = 8'h4D;
    localparam logic [7:0] SC_Q = 8'h15;
    localparam logic [7:0] SC_R = 8'h2D;
    localparam logic [7:0] SC_S = 8'h1B;
    localparam logic [7:0] SC_T = 8'h2C;
    localparam logic [7:0] SC_U = 8'h3C;
    localparam logic [7:0] SC_V = 8'h2A;
    localparam logic [7:0] SC_W = 8'h1D;
    localparam logic [7:0] SC_X = 8'h22;
    localparam logic [7:0] SC_Y = 8'h35;
    localparam logic [7:0] SC_Z = 8'h1A;

    // 0 = A .. 25 = Z
    typedef logic [4:0] letter_idx_t;

    // Decoder FSM: which prefix bytes have been seen so far.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

endpackage

// File: rtl/keystroke_decoder_if.sv
// Keyboard-to-rotor interface bundle.
// Handshake: scan_valid is a one-cycle strobe; scan_code is meaningful only
// in that cycle and there is no ready/backpressure (the decoder accepts every
// byte). letter_valid is likewise a one-cycle strobe with no ready; the
// consumer must act on it in the cycle it is high. letter_idx, letter_onehot
// and key_held are level outputs valid every cycle.
//   master : keyboard receiver side (drives scan bytes, observes letters)
//   slave  : decoder side
interface keystroke_decoder_if import enigma_pkg::*;;

    logic [7:0]              scan_code;
    logic                    scan_valid;
    logic                    letter_valid;
    letter_idx_t             letter_idx;
    logic [LETTER_COUNT-1:0] letter_onehot;
    logic                    key_held;

    modport master (
        output scan_code,
        output scan_valid,
        input  letter_valid,
        input  letter_idx,
        input  letter_onehot,
        input  key_held
    );

    modport slave (
        input  scan_code,
        input  scan_valid,
        output letter_valid,
        output letter_idx,
        output letter_onehot,
        output key_held
    );

endinterface

// File: rtl/keystroke_decoder_scan_to_letter.sv
// Combinational PS/2 set-2 make code to letter index lookup.
//   scan_code : byte to classify
//   is_letter : 1 when scan_code is one of the 26 letter make codes
//   idx       : 0=A .. 25=Z when is_letter, else 0
module scan_to_letter
    import enigma_pkg::*;
(
    input  logic [7:0]  scan_code,
    output logic        is_letter,
    output letter_idx_t idx
);

    always_comb begin
        is_letter = 1'b1;
        idx       = '0;
        case (scan_code)
            SC_A: idx = 5'd0;
            SC_B: idx = 5'd1;
            SC_C: idx = 5'd2;
            SC_D: idx = 5'd3;
            SC_E: idx = 5'd4;
            SC_F: idx = 5'd5;
            SC_G: idx = 5'd6;
            SC_H: idx = 5'd7;
            SC_I: idx = 5'd8;
            SC_J: idx = 5'd9;
            SC_K: idx = 5'd10;
            SC_L: idx = 5'd11;
            SC_M: idx = 5'd12;
            SC_N: idx = 5'd13;
            SC_O: idx = 5'd14;
            SC_P: idx = 5'd15;
            SC_Q: idx = 5'd16;
            SC_R: idx = 5'd17;
            SC_S: idx = 5'd18;
            SC_T: idx = 5'd19;
            SC_U: idx = 5'd20;
            SC_V: idx = 5'd21;
            SC_W: idx = 5'd22;
            SC_X: idx = 5'd23;
            SC_Y: idx = 5'd24;
            SC_Z: idx = 5'd25;
            default: is_letter = 1'b0;
        endcase
    end

endmodule

// File: rtl/keystroke_decoder.sv
// Turns the PS/2 set-2 byte stream into one strobe per letter key press.
// Tracks the currently held letter so typematic repeats can be suppressed
// and so the matching break code clears the held indication.
//   CLOCK_50  : clock, all state on rising edge
//   reset     : synchronous, active-high
//   kbd       : scan byte input and letter outputs (slave modport)
//   dbg_state : current FSM state, for observation only
module keystroke_decoder
    import enigma_pkg::*;
#(
    parameter int REPEAT_SUPPRESS = 1
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    keystroke_decoder_if.slave  kbd,
    output state_t              dbg_state
);

    state_t                  state;
    logic                    valid_q;
    letter_idx_t             idx_q;
    logic [LETTER_COUNT-1:0] onehot_q;
    logic                    held_q;
    logic [7:0]              held_code;

    logic                    dec_is_letter;
    letter_idx_t             dec_idx;
    logic                    new_press;

    scan_to_letter u_scan_to_letter (
        .scan_code (kbd.scan_code),
        .is_letter (dec_is_letter),
        .idx       (dec_idx)
    );

    // A letter make counts as a new press unless it is the typematic repeat
    // of the key already held and repeats are being suppressed.
    assign new_press = dec_is_letter &&
                       (!held_q || (kbd.scan_code != held_code) || (REPEAT_SUPPRESS == 0));

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= IDLE;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            onehot_q  <= '0;
            held_q    <= 1'b0;
            held_code <= 8'h00;
        end else begin
            valid_q <= 1'b0;
            if (kbd.scan_valid) begin
                case (state)
                    IDLE: begin
                        if (kbd.scan_code == BREAK_PREFIX) begin
                            state <= BRK;
                        end else if (kbd.scan_code == EXT_PREFIX) begin
                            state <= EXT;
                        end else if (new_press) begin
                            valid_q   <= 1'b1;
                            idx_q     <= dec_idx;
                            onehot_q  <= LETTER_COUNT'(1) << dec_idx;
                            held_q    <= 1'b1;
                            held_code <= kbd.scan_code;
                        end
                    end
                    BRK: begin
                        state <= IDLE;
                        // Only the break of the most recent letter releases it;
                        // breaks of rolled-over keys are ignored.
                        if (held_q && (kbd.scan_code == held_code)) begin
                            held_q   <= 1'b0;
                            onehot_q <= '0;
                        end
                    end
                    EXT: begin
                        state <= (kbd.scan_code == BREAK_PREFIX) ? EXT_BRK : IDLE;
                    end
                    EXT_BRK: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign kbd.letter_valid  = valid_q;
    assign kbd.letter_idx    = idx_q;
    assign kbd.letter_onehot = onehot_q;
    assign kbd.key_held      = held_q;
    assign dbg_state         = state;

endmodule
